// File: rtl/ahb_sub_mem_if.sv
// ---------------------------------------------------------------------------
// ahb_sub_mem_if
// AHB-Lite signal bundle between an initiator (or interconnect) and the
// ahb_sub_mem subordinate.
//   master modport : drives HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
//                    HWSTRB, HREADY; observes HREADYOUT, HRESP, HRDATA
//   slave modport  : the mirror image
// HREADY is the bus-wide ready returned by the interconnect. It sits on the
// master side because the subordinate only observes it.
// ---------------------------------------------------------------------------
interface ahb_sub_mem_if #(
  parameter int XLEN  = 64,
  parameter int ADDRW = 32
);
  logic                HSEL;
  logic [ADDRW-1:0]    HADDR;
  logic [1:0]          HTRANS;
  logic                HWRITE;
  logic [2:0]          HSIZE;
  logic [XLEN-1:0]     HWDATA;
  logic [XLEN/8-1:0]   HWSTRB;
  logic                HREADY;
  logic                HREADYOUT;
  logic                HRESP;
  logic [XLEN-1:0]     HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HWSTRB, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HWSTRB, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_sub_mem.sv
// ---------------------------------------------------------------------------
// ahb_sub_mem
// AHB-Lite subordinate backed by a word-addressed register array. Reads
// stall for WAIT_STATES cycles before data is returned. Writes complete in
// one data-phase cycle and commit HWDATA under HWSTRB. Out-of-range,
// misaligned or oversized transfers get a two-cycle ERROR response.
//
// Ports:
//   HCLK    : clock
//   HRESETn : asynchronous active-low reset
//   bus     : ahb_sub_mem_if.slave
//             inputs  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HWSTRB,
//                     HREADY
//             outputs HREADYOUT, HRESP, HRDATA
//
// Optional build macro:
//   AHB_SUB_MEM_WRITE_WAIT_EN : when defined, writes also stall for
//   WAIT_STATES cycles (state WWAIT) before the committing WDATA cycle.
// ---------------------------------------------------------------------------
module ahb_sub_mem #(
  parameter int XLEN        = 64,
  parameter int DEPTH       = 512,
  parameter int ADDRW       = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  ahb_sub_mem_if.slave  bus
);

  localparam int         OFFW    = $clog2(XLEN/8);
  localparam int         IDXW    = $clog2(DEPTH);
  localparam logic [2:0] WS_LOAD = 3'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RWAIT, S_RDONE, S_WDATA, S_WWAIT, S_ERR1, S_ERR2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  state_t            w_acc_state;
  logic [2:0]        r_cnt;
  logic [IDXW-1:0]   r_idx;
  logic [XLEN-1:0]   r_hrdata;
  logic [XLEN-1:0]   r_mem [DEPTH];

  logic              w_sel_xfer;
  logic              w_oor;
  logic              w_misalign;
  logic              w_oversize;
  logic              w_err;
  logic              w_ready;
  logic              w_resp;
  logic              w_take;
  logic              w_rd_load;
  logic [OFFW-1:0]   w_lowmask;
  logic [IDXW-1:0]   w_acc_idx;
  logic [IDXW-1:0]   w_load_idx;
  logic [XLEN-1:0]   w_load_data;
  logic              w_unused_htrans0;

  // Byte-strobed merge shared by the array write and read forwarding.
  function automatic logic [XLEN-1:0] f_merge(input logic [XLEN-1:0]   old_w,
                                               input logic [XLEN-1:0]   new_w,
                                               input logic [XLEN/8-1:0] strb);
    logic [XLEN-1:0] res;
    res = old_w;
    for (int b = 0; b < XLEN/8; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // SEQ and NONSEQ both have HTRANS[1] set. BUSY/IDLE are only told apart by bit 0.
  assign w_unused_htrans0 = bus.HTRANS[0];
  assign w_sel_xfer       = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
  assign w_acc_idx        = bus.HADDR[OFFW +: IDXW];

  // Address checks evaluated in the address phase.
  assign w_oor = (bus.HADDR >> (OFFW + IDXW)) != '0;

  always_comb begin
    w_lowmask = '0;
    for (int i = 0; i < OFFW; i++) w_lowmask[i] = (i < int'(bus.HSIZE));
  end

  assign w_misalign = |(bus.HADDR[OFFW-1:0] & w_lowmask);
  assign w_oversize = int'(bus.HSIZE) > OFFW;
  assign w_err      = w_oor | w_misalign | w_oversize;

  // State entered when a transfer is accepted this cycle.
  always_comb begin
    w_acc_state = S_IDLE;
    if (w_err) begin
      w_acc_state = S_ERR1;
    end else if (bus.HWRITE) begin
`ifdef AHB_SUB_MEM_WRITE_WAIT_EN
      w_acc_state = (WAIT_STATES > 0) ? S_WWAIT : S_WDATA;
`else
      w_acc_state = S_WDATA;
`endif
    end else begin
      w_acc_state = (WAIT_STATES > 0) ? S_RWAIT : S_RDONE;
    end
  end

  // Next state and outputs. Any state that drives HREADYOUT=1 may accept
  // the next transfer directly, which avoids an IDLE bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b1;
    w_resp      = 1'b0;
    w_take      = 1'b0;
    case (r_state)
      S_RWAIT: begin
        w_ready = 1'b0;
        if (r_cnt == '0) w_state_nxt = S_RDONE;
      end
      S_WWAIT: begin
        w_ready = 1'b0;
        if (r_cnt == '0) w_state_nxt = S_WDATA;
      end
      S_ERR1: begin
        w_ready     = 1'b0;
        w_resp      = 1'b1;
        w_state_nxt = S_ERR2;
      end
      S_ERR2: begin
        w_resp      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_take = w_ready & w_sel_xfer;
    if (w_take) w_state_nxt = w_acc_state;
  end

  // Read data capture. A zero-wait read loads straight from the address
  // phase. It may collide with a write committing on the same edge, so the
  // in-flight write is merged in to keep the array write-before-read ordered.
  always_comb begin
    w_rd_load  = 1'b0;
    w_load_idx = r_idx;
    if (r_state == S_RWAIT && r_cnt == '0) begin
      w_rd_load = 1'b1;
    end else if (w_take && !w_err && !bus.HWRITE && WAIT_STATES == 0) begin
      w_rd_load  = 1'b1;
      w_load_idx = w_acc_idx;
    end
    w_load_data = r_mem[w_load_idx];
    if (r_state == S_WDATA && r_idx == w_load_idx)
      w_load_data = f_merge(w_load_data, bus.HWDATA, bus.HWSTRB);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Data-phase registers. The counter reloads on every accept. Only the
  // wait states consume it.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_hrdata <= '0;
    end else begin
      if (w_take) begin
        r_idx <= w_acc_idx;
        r_cnt <= WS_LOAD;
      end else if (r_cnt != '0 && (r_state == S_RWAIT || r_state == S_WWAIT)) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (w_rd_load) r_hrdata <= w_load_data;
    end
  end

  // Array is not reset. Reset forces the FSM out of WDATA, which drops a
  // pending write.
  always_ff @(posedge HCLK) begin
    if (r_state == S_WDATA) r_mem[r_idx] <= f_merge(r_mem[r_idx], bus.HWDATA, bus.HWSTRB);
  end

  assign bus.HREADYOUT = w_ready;
  assign bus.HRESP     = w_resp;
  assign bus.HRDATA    = r_hrdata;

endmodule
